// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Arbiter and byte-serial sequencer for a shared byte-wide RAM
//            port. Serves instruction fetch (IF) and load/store (MEM)
//            requests one at a time. Reads are assembled into little-endian
//            words and completion is signalled by a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 17              // must be below 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_abort,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_data,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_cnt;       // active cycle index: cycle k after grant has r_cnt = k-1
    logic [2:0]        r_nbytes;    // transfer length in bytes (1, 2 or 4)
    logic [31:0]       r_rbuf;      // read bytes captured so far
    logic [31:0]       r_wbuf;      // store data latched at grant

    logic [2:0]        w_cnt_inc;
    logic [2:0]        w_mem_n;
    logic              w_grant_ok;
    logic [31:0]       w_rd_merged;
    logic [7:0]        w_wr_byte;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_wr;
    logic [7:0]        w_ram_dout;
    logic              w_if_done;
    logic [31:0]       w_if_data;
    logic              w_mem_done;
    logic [31:0]       w_mem_data;
    logic              w_busy;
    logic [2:0]        w_cnt;
    logic [2:0]        w_nbytes;
    logic [31:0]       w_rbuf;
    logic [31:0]       w_wbuf;

    // Address bits above the RAM width are deliberately dropped.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign w_cnt_inc = r_cnt + 3'd1;
    // New grants wait until the done pulse of the previous transfer is over.
    assign w_grant_ok = (r_state == S_IDLE) && !if_done && !mem_done;
    assign w_busy    = (w_state_nxt != S_IDLE);

    // Decode the requested load/store length; 11 behaves as a word.
    always_comb begin
        case (mem_len)
            2'b00:   w_mem_n = 3'd1;
            2'b01:   w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
    end

    // Read buffer with the byte arriving this cycle (byte r_cnt-1) merged in.
    always_comb begin
        w_rd_merged = r_rbuf;
        case (r_cnt)
            3'd1:    w_rd_merged[7:0]   = ram_din;
            3'd2:    w_rd_merged[15:8]  = ram_din;
            3'd3:    w_rd_merged[23:16] = ram_din;
            3'd4:    w_rd_merged[31:24] = ram_din;
            default: w_rd_merged = r_rbuf;
        endcase
    end

    // Store byte to present in the next active cycle.
    always_comb begin
        case (w_cnt_inc)
            3'd1:    w_wr_byte = r_wbuf[15:8];
            3'd2:    w_wr_byte = r_wbuf[23:16];
            3'd3:    w_wr_byte = r_wbuf[31:24];
            default: w_wr_byte = r_wbuf[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: MEM wins arbitration; IF abort kills only fetches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ok) begin
                    if (mem_req) begin
                        w_state_nxt = mem_we ? S_STORE : S_LOAD;
                    end else if (if_req && !if_abort) begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: if (if_abort || (r_cnt == r_nbytes)) w_state_nxt = S_IDLE;
            S_LOAD:  if (r_cnt == r_nbytes)               w_state_nxt = S_IDLE;
            S_STORE: if (w_cnt_inc == r_nbytes)           w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of every registered output and datapath register.
    always_comb begin
        w_ram_addr = ram_addr;
        w_ram_wr   = 1'b0;
        w_ram_dout = ram_dout;
        w_if_done  = 1'b0;
        w_if_data  = 32'h0;
        w_mem_done = 1'b0;
        w_mem_data = 32'h0;
        w_cnt      = r_cnt;
        w_nbytes   = r_nbytes;
        w_rbuf     = r_rbuf;
        w_wbuf     = r_wbuf;
        case (r_state)
            S_IDLE: begin
                if (w_state_nxt != S_IDLE) begin
                    w_cnt  = 3'd0;
                    w_rbuf = 32'h0;
                    if (mem_req) begin
                        w_ram_addr = mem_addr[ADDR_W-1:0];
                        w_nbytes   = w_mem_n;
                        w_wbuf     = mem_wdata;
                        if (mem_we) begin
                            w_ram_wr   = 1'b1;
                            w_ram_dout = mem_wdata[7:0];
                        end
                    end else begin
                        w_ram_addr = if_addr[ADDR_W-1:0];
                        w_nbytes   = 3'd4;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                // An aborted fetch freezes the address and discards the buffer.
                if (!((r_state == S_FETCH) && if_abort)) begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc < r_nbytes) begin
                        w_ram_addr = ram_addr + C_ADDR_ONE;
                    end
                    if (r_cnt != 3'd0) begin
                        w_rbuf = w_rd_merged;
                    end
                    if (r_cnt == r_nbytes) begin
                        if (r_state == S_FETCH) begin
                            w_if_done = 1'b1;
                            w_if_data = w_rd_merged;
                        end else begin
                            w_mem_done = 1'b1;
                            w_mem_data = w_rd_merged;
                        end
                    end
                end
            end
            S_STORE: begin
                w_cnt = w_cnt_inc;
                if (w_cnt_inc < r_nbytes) begin
                    w_ram_wr   = 1'b1;
                    w_ram_addr = ram_addr + C_ADDR_ONE;
                    w_ram_dout = w_wr_byte;
                end else begin
                    w_mem_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= 8'h0;
            if_done  <= 1'b0;
            if_data  <= 32'h0;
            mem_done <= 1'b0;
            mem_data <= 32'h0;
            busy     <= 1'b0;
            r_cnt    <= 3'd0;
            r_nbytes <= 3'd0;
            r_rbuf   <= 32'h0;
            r_wbuf   <= 32'h0;
        end else begin
            ram_addr <= w_ram_addr;
            ram_wr   <= w_ram_wr;
            ram_dout <= w_ram_dout;
            if_done  <= w_if_done;
            if_data  <= w_if_data;
            mem_done <= w_mem_done;
            mem_data <= w_mem_data;
            busy     <= w_busy;
            r_cnt    <= w_cnt;
            r_nbytes <= w_nbytes;
            r_rbuf   <= w_rbuf;
            r_wbuf   <= w_wbuf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl with a behavioural byte RAM
//            and a scoreboard of expected read words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic              if_abort = 1'b0;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_len = 2'b00;
    logic [31:0]       mem_addr = 32'h0;
    logic [31:0]       mem_wdata = 32'h0;
    logic [31:0]       mem_data;
    logic              mem_done;
    logic [7:0]        ram_din = 8'h0;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic              busy;

    logic [7:0]  ram [0:(1<<ADDR_W)-1];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data), .mem_done(mem_done),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ram_wr(ram_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data one cycle after the address, write on ram_wr.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({if_done, mem_done, ram_wr, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {if_done, mem_done, ram_wr, busy});
        end
        n_cmp++;
        if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
        n_cmp++;
        if ({if_data, mem_data, ram_dout} !== 72'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0", if_data, mem_data, ram_dout);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_word_fetch();
        logic [31:0] e;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        exp_if_q.push_back(32'h00100513);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                n_cmp++;
                if ({ram_wr, ram_addr} !== {1'b0, 17'(32'h100 + k - 1)}) begin
                    n_bad++; $display("FAIL fetch_addr c%0d: got wr=%b addr=%h want addr=%h", k, ram_wr, ram_addr, 32'h100 + k - 1);
                end
            end
            n_cmp++;
            if (if_done !== (k == 6)) begin n_bad++; $display("FAIL fetch_done c%0d: got %b", k, if_done); end
            n_cmp++;
            if (busy !== (k <= 5)) begin n_bad++; $display("FAIL fetch_busy c%0d: got %b", k, busy); end
            if (if_done && exp_if_q.size() > 0) begin
                e = exp_if_q.pop_front();
                n_cmp++;
                if (if_data !== e) begin n_bad++; $display("FAIL fetch_data: got %h want %h", if_data, e); end
                if_req = 1'b0;
            end
            if (k == 7) begin
                n_cmp++;
                if (if_data !== 32'h0) begin n_bad++; $display("FAIL fetch_data_idle: got %h want 0", if_data); end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_priority();
        int mem_cyc = -1;
        int if_cyc = -1;
        logic [31:0] e;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h100;
        exp_mem_q.push_back(32'hDEADBEEF);
        exp_if_q.push_back(32'h00100513);
        for (int k = 1; k <= 30 && if_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (ram_addr !== 17'h200) begin n_bad++; $display("FAIL prio_first: got addr %h want 00200", ram_addr); end
            end
            n_cmp++;
            if ((if_done & mem_done) !== 1'b0) begin n_bad++; $display("FAIL prio_overlap c%0d: both done", k); end
            if (mem_done && exp_mem_q.size() > 0) begin
                mem_cyc = k;
                e = exp_mem_q.pop_front();
                n_cmp++;
                if (mem_data !== e) begin n_bad++; $display("FAIL prio_mem_data: got %h want %h", mem_data, e); end
                mem_req = 1'b0;
            end
            if (if_done && exp_if_q.size() > 0) begin
                if_cyc = k;
                e = exp_if_q.pop_front();
                n_cmp++;
                if (if_data !== e) begin n_bad++; $display("FAIL prio_if_data: got %h want %h", if_data, e); end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (mem_cyc !== 6) begin n_bad++; $display("FAIL prio_mem_cycle: got %0d want 6", mem_cyc); end
        n_cmp++;
        if (if_cyc !== 13) begin n_bad++; $display("FAIL prio_if_cycle: got %0d want 13", if_cyc); end
        mem_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_store_half();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01;
        mem_addr = 32'h0001FFFF; mem_wdata = 32'h1234ABCD;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if ({ram_wr, ram_addr, ram_dout} !== {1'b1, 17'h1FFFF, 8'hCD}) begin
                    n_bad++; $display("FAIL store_c1: got wr=%b addr=%h dout=%h want 1/1ffff/cd", ram_wr, ram_addr, ram_dout);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if ({ram_wr, ram_addr, ram_dout} !== {1'b1, 17'h00000, 8'hAB}) begin
                    n_bad++; $display("FAIL store_c2: got wr=%b addr=%h dout=%h want 1/00000/ab", ram_wr, ram_addr, ram_dout);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if ({ram_wr, mem_done} !== 2'b01) begin
                    n_bad++; $display("FAIL store_done: got wr=%b done=%b want 0/1", ram_wr, mem_done);
                end
                mem_req = 1'b0; mem_we = 1'b0;
            end
            if (k == 4) begin
                n_cmp++;
                if ({mem_done, busy} !== 2'b00) begin
                    n_bad++; $display("FAIL store_after: got done=%b busy=%b want 0/0", mem_done, busy);
                end
            end
        end
        mem_req = 1'b0; mem_we = 1'b0;
        n_cmp++;
        if ({ram[17'h1FFFF], ram[0]} !== 16'hCDAB) begin
            n_bad++; $display("FAIL store_ram: got %h %h want cd ab", ram[17'h1FFFF], ram[0]);
        end
    endtask

    task automatic test_len_load();
        logic [31:0] addrs [2] = '{32'hABC00040, 32'h00000201};
        logic [1:0]  lens  [2] = '{2'b00, 2'b01};
        logic [31:0] exps  [2] = '{32'h000000F0, 32'h0000ADBE};
        int          dcyc  [2] = '{3, 4};
        logic [31:0] e;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_we = 1'b0; mem_len = lens[t]; mem_addr = addrs[t];
            exp_mem_q.push_back(exps[t]);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_cmp++;
                    if (ram_addr !== addrs[t][ADDR_W-1:0]) begin
                        n_bad++; $display("FAIL load%0d_addr: got %h want %h", t, ram_addr, addrs[t][ADDR_W-1:0]);
                    end
                end
                n_cmp++;
                if (mem_done !== (k == dcyc[t])) begin n_bad++; $display("FAIL load%0d_done c%0d: got %b", t, k, mem_done); end
                if (mem_done && exp_mem_q.size() > 0) begin
                    e = exp_mem_q.pop_front();
                    n_cmp++;
                    if (mem_data !== e) begin n_bad++; $display("FAIL load%0d_data: got %h want %h", t, mem_data, e); end
                    mem_req = 1'b0;
                end
            end
            mem_req = 1'b0;
        end
    endtask

    task automatic test_fetch_abort();
        logic [31:0] e;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_done !== 1'b0) begin n_bad++; $display("FAIL abort_done c%0d: got 1 want 0", k); end
            if (k == 4 || k == 5) begin
                n_cmp++;
                if ({busy, ram_addr} !== {1'b0, 17'h102}) begin
                    n_bad++; $display("FAIL abort_hold c%0d: got busy=%b addr=%h want 0/00102", k, busy, ram_addr);
                end
            end
            if (k == 3) begin if_abort = 1'b1; if_req = 1'b0; end
            if (k == 4) if_abort = 1'b0;
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        exp_if_q.push_back(32'h003102B3);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_done !== (k == 6)) begin n_bad++; $display("FAIL refetch_done c%0d: got %b", k, if_done); end
            if (if_done && exp_if_q.size() > 0) begin
                e = exp_if_q.pop_front();
                n_cmp++;
                if (if_data !== e) begin n_bad++; $display("FAIL refetch_data: got %h want %h", if_data, e); end
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] e;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
        mem_addr = 32'h500; mem_wdata = 32'h11223344;
        @(negedge clk);
        n_cmp++;
        if (ram_wr !== 1'b1) begin n_bad++; $display("FAIL rst_store_c1: got wr=%b want 1", ram_wr); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_wr, busy, mem_done} !== 3'b000) begin
            n_bad++; $display("FAIL rst_async: got wr=%b busy=%b done=%b want 0", ram_wr, busy, mem_done);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk) rst = 1'b0;
        n_cmp++;
        if ({ram[17'h500], ram[17'h501]} !== 16'h4400) begin
            n_bad++; $display("FAIL rst_partial: got %h %h want 44 00", ram[17'h500], ram[17'h501]);
        end
        @(negedge clk);
        mem_req = 1'b1; mem_len = 2'b00; mem_addr = 32'h40;
        exp_mem_q.push_back(32'h000000F0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_done !== (k == 3)) begin n_bad++; $display("FAIL post_rst_done c%0d: got %b", k, mem_done); end
            if (mem_done && exp_mem_q.size() > 0) begin
                e = exp_mem_q.pop_front();
                n_cmp++;
                if (mem_data !== e) begin n_bad++; $display("FAIL post_rst_data: got %h want %h", mem_data, e); end
                mem_req = 1'b0;
            end
        end
        mem_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[0] = 8'h55;
        {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]} = 32'h00100513;
        {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]} = 32'hDEADBEEF;
        {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]} = 32'h003102B3;
        ram[17'h40] = 8'hF0;
        ram[17'h41] = 8'h77;

        test_reset();
        test_word_fetch();
        test_priority();
        test_store_half();
        test_len_load();
        test_fetch_abort();
        test_reset_mid_store();

        n_cmp++;
        if ((exp_if_q.size() + exp_mem_q.size()) !== 0) begin
            n_bad++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_if_q.size() + exp_mem_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
